// File: rtl/add_arb_pkg.sv
// rtl/add_arb_pkg.sv - shared types and widths for the two-requester adder arbiter
package add_arb_pkg;

  localparam int OPW  = 17;
  localparam int SUMW = 18;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef logic req_id_t;

  function automatic req_id_t other_req(input req_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/adder17.sv
// rtl/adder17.sv - 17-bit ripple-carry adder, 18-bit sum with carry-out in the top bit
module adder17
  import add_arb_pkg::*;
(
  input  logic [OPW-1:0]  a,
  input  logic [OPW-1:0]  b,
  output logic [SUMW-1:0] sum
);

  logic [OPW:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < OPW; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign sum[OPW] = carry[OPW];

endmodule

// File: rtl/add_arbiter.sv
// rtl/add_arbiter.sv - round-robin arbiter feeding one shared adder, one-deep result register
// Optional per-requester grant counters when ADD_ARB_STATS_EN is defined.
module add_arbiter
  import add_arb_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OPW-1:0]  req0_a,
  input  logic [OPW-1:0]  req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OPW-1:0]  req1_a,
  input  logic [OPW-1:0]  req1_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [SUMW-1:0] rsp_sum,
  output req_id_t         rsp_id
`ifdef ADD_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
`endif
);

  state_t          state;
  req_id_t         prio;
  logic            can_accept;
  logic            gnt_valid;
  req_id_t         gnt_id;
  logic            accept;
  logic [OPW-1:0]  op_a;
  logic [OPW-1:0]  op_b;
  logic [SUMW-1:0] sum;

  // Readys are forced low while reset is asserted, even though state already reads IDLE.
  assign can_accept = rst_n && ((state == IDLE) || rsp_ready);

  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_valid = 1'b1;
      gnt_id    = prio;
    end else if (req0_valid) begin
      gnt_valid = 1'b1;
      gnt_id    = 1'b0;
    end else if (req1_valid) begin
      gnt_valid = 1'b1;
      gnt_id    = 1'b1;
    end
  end

  assign req0_ready = can_accept && gnt_valid && (gnt_id == 1'b0);
  assign req1_ready = can_accept && gnt_valid && (gnt_id == 1'b1);
  assign accept     = can_accept && gnt_valid;

  assign op_a = gnt_id ? req1_a : req0_a;
  assign op_b = gnt_id ? req1_b : req0_b;

  adder17 u_adder (
    .a   (op_a),
    .b   (op_b),
    .sum (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_id    <= 1'b0;
      prio      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= HOLD;
            rsp_valid <= 1'b1;
            rsp_sum   <= sum;
            rsp_id    <= gnt_id;
            prio      <= other_req(gnt_id);
          end
        end
        HOLD: begin
          // A drain and a fresh accept on the same edge keep the pipeline full.
          if (accept) begin
            rsp_sum <= sum;
            rsp_id  <= gnt_id;
            prio    <= other_req(gnt_id);
          end else if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ADD_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else if (accept) begin
      if (gnt_id == 1'b0) gnt_cnt0 <= gnt_cnt0 + 1'b1;
      else                gnt_cnt1 <= gnt_cnt1 + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_add_arbiter.sv
// tb/tb_add_arbiter.sv - scoreboard bench for add_arbiter with random and directed stimulus
module tb_add_arbiter;

  localparam int CNT_W = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [16:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready;
  logic [17:0] rsp_sum;
  logic        rsp_id;
`ifdef ADD_ARB_STATS_EN
  logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;
`endif

  add_arbiter #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_id     (rsp_id)
`ifdef ADD_ARB_STATS_EN
    ,
    .gnt_cnt0   (gnt_cnt0),
    .gnt_cnt1   (gnt_cnt1)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned id;
    int unsigned sum;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model state: whose turn a tie goes to, whether a result is outstanding.
  int unsigned m_prio = 0;
  bit          m_held = 0;
  int unsigned m_cnt0 = 0, m_cnt1 = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: whenever a result is presented it must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_rsp", 1, 0);
        end else begin
          check("rsp_sum", rsp_sum, exp_q[0].sum);
          check("rsp_id", rsp_id, exp_q[0].id);
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic model_reset();
    m_prio = 0;
    m_held = 0;
    m_cnt0 = 0;
    m_cnt1 = 0;
    exp_q.delete();
  endtask

  task automatic step(input bit v0, input int unsigned a0, input int unsigned b0,
                      input bit v1, input int unsigned a1, input int unsigned b1,
                      input bit rr);
    bit          can, any;
    int unsigned win;
    exp_t        e;
    @(posedge clk);
    #1;
    req0_valid = v0; req0_a = a0[16:0]; req0_b = b0[16:0];
    req1_valid = v1; req1_a = a1[16:0]; req1_b = b1[16:0];
    rsp_ready  = rr;
    #1;
    can = !m_held || rr;
    any = v0 || v1;
    win = (v0 && v1) ? m_prio : (v0 ? 0 : 1);
    check("req0_ready", req0_ready, can && any && win == 0);
    check("req1_ready", req1_ready, can && any && win == 1);
`ifdef ADD_ARB_STATS_EN
    check("gnt_cnt0", gnt_cnt0, m_cnt0 % (1 << CNT_W));
    check("gnt_cnt1", gnt_cnt1, m_cnt1 % (1 << CNT_W));
`endif
    if (can && any) begin
      e.id  = win;
      e.sum = (win == 0) ? (a0 % 32'h20000) + (b0 % 32'h20000)
                         : (a1 % 32'h20000) + (b1 % 32'h20000);
      exp_q.push_back(e);
      m_prio = 1 - win;
      m_held = 1;
      if (win == 0) m_cnt0++; else m_cnt1++;
    end else if (rr) begin
      m_held = 0;
    end
  endtask

  function automatic int unsigned rnd_op();
    case ($urandom_range(0, 3))
      0:       return 32'h1FFFF;
      1:       return $urandom_range(0, 3);
      default: return $urandom_range(0, 32'h1FFFF);
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 17'd1; req0_b = 17'd1;
    req1_valid = 1'b1; req1_a = 17'd2; req1_b = 17'd2;
    rsp_ready = 1'b1;
    #12;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_sum", rsp_sum, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Single request latency, then alternating ties at full throughput.
    step(1, 5, 7, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(1, i, 100, 1, 1000, i, 1);

    // Back-pressure with req1 waiting, then release.
    step(1, 3, 4, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 9, 9, 0);
    step(0, 0, 0, 1, 9, 9, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // Carry-out boundaries.
    step(1, 32'h1FFFF, 32'h1FFFF, 0, 0, 0, 1);
    step(0, 0, 0, 1, 32'h1FFFF, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 1), rnd_op(), rnd_op(), $urandom_range(0, 1), rnd_op(), rnd_op(),
           $urandom_range(0, 9) < 7);

`ifdef ADD_ARB_STATS_EN
    for (int i = 0; i < 257; i++) step(1, i, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
`endif

    // Reset while a result is held: it must vanish at once and never be emitted.
    step(0, 0, 0, 1, 20, 22, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_rsp_sum", rsp_sum, 0);
    check("midrst_req1_ready", req1_ready, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 11, 12, 1, 13, 14, 1);
    step(1, 15, 16, 1, 17, 18, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1);

    @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
